time_set_ctrl: RTL

//  Time-setting controller and 1 Hz scheduler for the clock counter. Divides CP_1kHz
//  to produce CP_1Hz, debounces the MODE/ADJ keys and runs a RUN/SET_HOUR/SET_MIN FSM.

---
 rtl/time_set_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting controller: 1 Hz divider, key debounce, RUN/SET_HOUR/SET_MIN FSM,
// one-increment-per-press adj requests with auto-repeat, timeout and blink flags.
module time_set_ctrl #(
  parameter int unsigned CLK_HZ         = 1000,
  parameter int unsigned DEBOUNCE_MS    = 20,
  parameter int unsigned REPEAT_DELAY_S = 1,
  parameter int unsigned TIMEOUT_S      = 10
) (
  input  logic       CP_1kHz,
  input  logic       _CR,
  input  logic       key_mode,
  input  logic       key_adj,
  output logic       CP_1Hz,
  output logic       hour_adj,
  output logic       min_adj,
  output logic [1:0] set_mode,
  output logic       blank_hour,
  output logic       blank_min
);

  localparam int unsigned HALF    = CLK_HZ / 2;
  localparam int unsigned QUARTER = CLK_HZ / 4;
  localparam int unsigned DB_RAW  = DEBOUNCE_MS * CLK_HZ / 1000;
  localparam int unsigned DB_CNT  = (DB_RAW == 0) ? 1 : DB_RAW;
  localparam int unsigned DIV_W   = $clog2(CLK_HZ);
  localparam int unsigned BLK_W   = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int unsigned DB_W    = $clog2(DB_CNT + 1);
  localparam int unsigned HOLD_W  = (REPEAT_DELAY_S > 0) ? $clog2(REPEAT_DELAY_S + 1) : 1;
  localparam int unsigned IDLE_W  = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

  typedef enum logic [1:0] {ST_RUN = 2'b00, ST_HOUR = 2'b01, ST_MIN = 2'b10} state_e;

  logic [DIV_W-1:0]         div_q;
  logic                     cp_q;
  logic [BLK_W-1:0]         blk_q;
  logic                     phase_q;
  logic [1:0]               sync1_q, sync2_q, deb_q;
  logic [1:0][DB_W-1:0]     dbc_q;
  logic [HOLD_W-1:0]        hold_q;
  logic [IDLE_W-1:0]        idle_q, idle_d;
  logic                     pend_q, pend_d;
  logic                     hour_adj_q, hour_adj_d;
  logic                     min_adj_q, min_adj_d;
  logic                     blank_hour_q, blank_hour_d;
  logic                     blank_min_q, blank_min_d;
  state_e                   state_q, state_d;

  logic       rise_c, fall_c, mode_press_c, adj_press_c, repeat_c, timeout_c;
  logic [1:0] press_c;

  // 1 Hz divider and 2 Hz blink phase
  always_ff @(posedge CP_1kHz or negedge _CR) begin
    if (!_CR) begin
      div_q   <= '0;
      cp_q    <= 1'b0;
      blk_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q <= (div_q == DIV_W'(CLK_HZ - 1)) ? '0 : div_q + DIV_W'(1);
      cp_q  <= (div_q < DIV_W'(HALF));
      if (blk_q == BLK_W'(QUARTER - 1)) begin
        blk_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        blk_q <= blk_q + BLK_W'(1);
      end
    end
  end

  // rise_c/fall_c mark the cycle whose closing edge moves CP_1Hz up/down
  assign rise_c = (div_q == '0);
  assign fall_c = (div_q == DIV_W'(HALF));

  // Key synchroniser and debounce; bit 0 = MODE, bit 1 = ADJ
  always_ff @(posedge CP_1kHz or negedge _CR) begin
    if (!_CR) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      dbc_q   <= '0;
    end else begin
      sync1_q <= {key_adj, key_mode};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dbc_q[i] <= '0;
        end else if (dbc_q[i] == DB_W'(DB_CNT - 1)) begin
          deb_q[i] <= sync2_q[i];
          dbc_q[i] <= '0;
        end else begin
          dbc_q[i] <= dbc_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    press_c = '0;
    for (int i = 0; i < 2; i++) begin
      press_c[i] = sync2_q[i] && !deb_q[i] && (dbc_q[i] == DB_W'(DB_CNT - 1));
    end
  end

  assign mode_press_c = press_c[0];
  assign adj_press_c  = press_c[1] && !press_c[0];

  // Held-ADJ seconds counter, saturating at the repeat delay
  always_ff @(posedge CP_1kHz or negedge _CR) begin
    if (!_CR) begin
      hold_q <= '0;
    end else if (!deb_q[1]) begin
      hold_q <= '0;
    end else if (rise_c && (hold_q != HOLD_W'(REPEAT_DELAY_S))) begin
      hold_q <= hold_q + HOLD_W'(1);
    end
  end

  assign repeat_c  = fall_c && deb_q[1] && (hold_q == HOLD_W'(REPEAT_DELAY_S)) &&
                     (state_q != ST_RUN);
  assign timeout_c = rise_c && (state_q != ST_RUN) && !adj_press_c &&
                     (idle_q == IDLE_W'(TIMEOUT_S - 1));

  always_ff @(posedge CP_1kHz or negedge _CR) begin
    if (!_CR) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mode_press_c) begin
      case (state_q)
        ST_RUN:  state_d = ST_HOUR;
        ST_HOUR: state_d = ST_MIN;
        default: state_d = ST_RUN;
      endcase
    end else if (timeout_c) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    pend_d     = pend_q;
    hour_adj_d = hour_adj_q;
    min_adj_d  = min_adj_q;
    idle_d     = idle_q;
    if (fall_c) begin
      hour_adj_d = (pend_q || repeat_c) && !mode_press_c && (state_q == ST_HOUR);
      min_adj_d  = (pend_q || repeat_c) && !mode_press_c && (state_q == ST_MIN);
      pend_d     = 1'b0;
    end
    if (adj_press_c && (state_q != ST_RUN)) pend_d = 1'b1;
    if (mode_press_c || timeout_c) pend_d = 1'b0;
    // An auto-repeat step counts as user activity so holding ADJ never times out
    if ((state_d != state_q) || (press_c != 2'b00) || repeat_c) begin
      idle_d = '0;
    end else if (rise_c && (state_q != ST_RUN)) begin
      idle_d = idle_q + IDLE_W'(1);
    end
    blank_hour_d = (state_d == ST_HOUR) && phase_q;
    blank_min_d  = (state_d == ST_MIN) && phase_q;
  end

  always_ff @(posedge CP_1kHz or negedge _CR) begin
    if (!_CR) begin
      pend_q       <= 1'b0;
      hour_adj_q   <= 1'b0;
      min_adj_q    <= 1'b0;
      idle_q       <= '0;
      blank_hour_q <= 1'b0;
      blank_min_q  <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      hour_adj_q   <= hour_adj_d;
      min_adj_q    <= min_adj_d;
      idle_q       <= idle_d;
      blank_hour_q <= blank_hour_d;
      blank_min_q  <= blank_min_d;
    end
  end

  assign CP_1Hz     = cp_q;
  assign hour_adj   = hour_adj_q;
  assign min_adj    = min_adj_q;
  assign set_mode   = state_q;
  assign blank_hour = blank_hour_q;
  assign blank_min  = blank_min_q;

endmodule
